// File: rtl/store_buffer.sv
// Posted-write store buffer between a single-cycle core data port and a wait-stated memory.
// Stores are queued without stalling the core, and loads are forwarded from the youngest matching
// buffered store when possible. Load misses go to memory while core_stall holds the core.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   core_we/core_re       store / load request (a store wins if both are set)
//   core_addr/core_wdata  byte address (bits [1:0] ignored) and store data
//   core_rdata            load data, combinational (forwarded or from memory)
//   core_stall            core must hold PC and suppress register writes this cycle
//   buf_empty             no buffered stores and no memory operation outstanding
//   mem_req/mem_we        memory request (held until mem_gnt) and its direction
//   mem_addr/mem_wdata    word-aligned address and write data, stable while mem_req=1
//   mem_gnt               memory accepts the request this cycle
//   mem_rvalid/mem_rdata  single-cycle read data return
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_we,
  input  logic          core_re,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  output logic          buf_empty,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned WW = AW - 2;

  typedef enum logic [1:0] {StIdle, StWrReq, StLdReq, StLdWait} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [WW-1:0] core_word;
  logic          load_req, full, push, pop, hit, miss, rd_done;
  logic [DW-1:0] fwd_data;
  logic          unused_addr_lsb;

  assign core_word       = core_addr[AW-1:2];
  assign unused_addr_lsb = ^core_addr[1:0];
  assign load_req        = core_re & ~core_we;
  assign full            = (count_q == CW'(DEPTH));
  // A pop in the same cycle does not free the slot for a store that found the buffer full.
  assign push            = core_we & ~full;
  assign pop             = (state_q == StWrReq) & mem_gnt;
  assign miss            = load_req & ~hit;
  assign rd_done         = (state_q == StLdWait) & mem_rvalid;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    logic [PW-1:0] idx;
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == core_word)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // FIFO pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= core_word;
      data_q[tail_q] <= core_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state. Misses may overtake drains: a miss has no matching buffered address.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (miss)                 state_d = StLdReq;
        else if (count_q != '0)   state_d = StWrReq;
      end
      StWrReq: begin
        // A write request is never withdrawn; only a grant moves on.
        if (mem_gnt) begin
          if (miss)                    state_d = StLdReq;
          else if (count_q > CW'(1))   state_d = StWrReq;
          else                         state_d = StIdle;
        end
      end
      StLdReq: begin
        if (mem_gnt) state_d = StLdWait;
      end
      StLdWait: begin
        if (mem_rvalid) state_d = (count_q != '0) ? StWrReq : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and core-facing outputs.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StWrReq: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[head_q], 2'b00};
        mem_wdata = data_q[head_q];
      end
      StLdReq: begin
        mem_req  = 1'b1;
        mem_addr = {core_word, 2'b00};
      end
      default: ;
    endcase

    // Core outputs read as idle while reset is held, even if the core still requests.
    core_stall = ~reset & ((core_we & full) | (miss & ~rd_done));
    core_rdata = '0;
    if (~reset & load_req) begin
      if (hit)          core_rdata = fwd_data;
      else if (rd_done) core_rdata = mem_rdata;
    end
    buf_empty = (count_q == '0) & (state_q == StIdle);
  end

endmodule
